// File: rtl/data_path_param.sv
// Parametrised two-bus data path: PC, MAR, IR, CCR, N-entry register file.
// Optional stack pointer built when DATA_PATH_SP_EN is defined.
module data_path_param #(
   parameter int                DATA_W   = 8,
   parameter int                ADDR_W   = 8,
   parameter int                NUM_REGS = 4,
   parameter logic [ADDR_W-1:0] SP_RESET = '1,
   localparam int               RS_W     = $clog2(NUM_REGS)
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic [DATA_W-1:0] from_memory,
   input  logic [2:0]        ALU_Sel,
   input  logic [1:0]        Bus1_Sel,
   input  logic [1:0]        Bus2_Sel,
   input  logic [RS_W-1:0]   Rd_Sel1,
   input  logic [RS_W-1:0]   Rd_Sel2,
   input  logic [RS_W-1:0]   Wr_Sel,
   input  logic              IR_Load,
   input  logic              MAR_Load,
   input  logic              PC_Load,
   input  logic              PC_Inc,
   input  logic              Reg_Load,
   input  logic              CCR_Load,
   input  logic              SP_Inc,
   input  logic              SP_Dec,
   output logic [ADDR_W-1:0] address,
   output logic [DATA_W-1:0] to_memory,
   output logic [DATA_W-1:0] IR_out,
   output logic [3:0]        CCR_Result
);

   localparam int MSB = DATA_W - 1;

   logic [ADDR_W-1:0] pc;
   logic [ADDR_W-1:0] mar;
   logic [DATA_W-1:0] ir;
   logic [3:0]        ccr;
   logic [DATA_W-1:0] regs [NUM_REGS];

   logic [DATA_W-1:0] sp_bus;
   logic [DATA_W-1:0] bus1;
   logic [DATA_W-1:0] bus2;
   logic [DATA_W-1:0] x;
   logic [DATA_W-1:0] y;
   logic [DATA_W-1:0] opb;
   logic [DATA_W-1:0] res;
   logic [DATA_W:0]   wide;
   logic              cin;
   logic              sub;
   logic              arith;
   logic              n_f;
   logic              z_f;
   logic              v_f;
   logic              c_f;

`ifdef DATA_PATH_SP_EN
   logic [ADDR_W-1:0] sp;

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         sp <= SP_RESET;
      end else if (SP_Inc && !SP_Dec) begin
         sp <= sp + ADDR_W'(1);
      end else if (SP_Dec && !SP_Inc) begin
         sp <= sp - ADDR_W'(1);
      end
   end

   assign sp_bus = DATA_W'(sp);
`else
   logic sp_unused;

   assign sp_unused = ^{SP_Inc, SP_Dec, SP_RESET};
   assign sp_bus    = '0;
`endif

   always_comb begin
      bus1 = '0;
      unique case (Bus1_Sel)
         2'd0: bus1 = DATA_W'(pc);
         2'd1: bus1 = regs[Rd_Sel1];
         2'd2: bus1 = regs[Rd_Sel2];
         2'd3: bus1 = sp_bus;
      endcase
   end

   // Arithmetic ops share one adder/subtractor; logic ops bypass it.
   always_comb begin
      x     = bus1;
      y     = regs[Rd_Sel2];
      opb   = y;
      cin   = 1'b0;
      sub   = 1'b0;
      arith = 1'b1;
      res   = '0;
      wide  = '0;
      unique case (ALU_Sel)
         3'b000: ;
         3'b001: sub = 1'b1;
         3'b010: begin arith = 1'b0; res = x & y; end
         3'b011: begin arith = 1'b0; res = x | y; end
         3'b100: opb = DATA_W'(1);
         3'b101: begin opb = DATA_W'(1); sub = 1'b1; end
         3'b110: cin = ccr[0];
         3'b111: begin arith = 1'b0; res = x ^ y; end
      endcase
      c_f = 1'b0;
      v_f = 1'b0;
      if (arith) begin
         if (sub) begin
            wide = {1'b0, x} - {1'b0, opb};
            v_f  = (x[MSB] != opb[MSB]) && (wide[MSB] != x[MSB]);
         end else begin
            wide = {1'b0, x} + {1'b0, opb} + {{DATA_W{1'b0}}, cin};
            v_f  = (x[MSB] == opb[MSB]) && (wide[MSB] != x[MSB]);
         end
         res = wide[MSB:0];
         c_f = wide[DATA_W];
      end
      n_f = res[MSB];
      z_f = (res == '0);
   end

   always_comb begin
      bus2 = '0;
      unique case (Bus2_Sel)
         2'd0: bus2 = res;
         2'd1: bus2 = bus1;
         2'd2: bus2 = from_memory;
         2'd3: bus2 = '0;
      endcase
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         pc  <= '0;
         mar <= '0;
         ir  <= '0;
         ccr <= '0;
         for (int i = 0; i < NUM_REGS; i++) begin
            regs[i] <= '0;
         end
      end else begin
         if (IR_Load) ir <= bus2;
         if (MAR_Load) mar <= bus2[ADDR_W-1:0];
         if (PC_Load) begin
            pc <= bus2[ADDR_W-1:0];
         end else if (PC_Inc) begin
            pc <= pc + ADDR_W'(1);
         end
         if (CCR_Load) ccr <= {n_f, z_f, v_f, c_f};
         if (Reg_Load) regs[Wr_Sel] <= bus2;
      end
   end

   assign address    = mar;
   assign to_memory  = bus1;
   assign IR_out     = ir;
   assign CCR_Result = ccr;

endmodule

// File: tb/tb_data_path_param.sv
// Bench for data_path_param: directed vector table, reset sequence,
// and random stimulus against an arithmetic reference model.
module tb_data_path_param;

`ifdef DATA_PATH_SP_EN
   localparam bit SP_EN = 1'b1;
`else
   localparam bit SP_EN = 1'b0;
`endif

   localparam logic [7:0] S_IR  = 8'h80;
   localparam logic [7:0] S_MAR = 8'h40;
   localparam logic [7:0] S_PCL = 8'h20;
   localparam logic [7:0] S_PCI = 8'h10;
   localparam logic [7:0] S_REG = 8'h08;
   localparam logic [7:0] S_CCR = 8'h04;
   localparam logic [7:0] S_SPI = 8'h02;
   localparam logic [7:0] S_SPD = 8'h01;

   typedef struct {
      logic [7:0] fm;
      logic [2:0] alu;
      logic [1:0] b1;
      logic [1:0] b2;
      logic [1:0] rs1;
      logic [1:0] rs2;
      logic [1:0] ws;
      logic [7:0] st;
      logic [7:0] e_tm;
      logic [7:0] e_addr;
      logic [7:0] e_ir;
      logic [3:0] e_ccr;
   } vec_t;

   logic       Clk = 1'b0;
   logic       Reset = 1'b0;
   logic [7:0] from_memory;
   logic [2:0] ALU_Sel;
   logic [1:0] Bus1_Sel, Bus2_Sel, Rd_Sel1, Rd_Sel2, Wr_Sel;
   logic       IR_Load, MAR_Load, PC_Load, PC_Inc;
   logic       Reg_Load, CCR_Load, SP_Inc, SP_Dec;
   logic [7:0] address, to_memory, IR_out;
   logic [3:0] CCR_Result;

   int n_cmp = 0;
   int n_bad = 0;

   logic [7:0] m_pc, m_mar, m_ir, m_sp;
   logic [3:0] m_ccr;
   logic [7:0] m_r [4];

   vec_t tab [22];

   data_path_param dut (
      .Clk(Clk), .Reset(Reset), .from_memory(from_memory),
      .ALU_Sel(ALU_Sel), .Bus1_Sel(Bus1_Sel), .Bus2_Sel(Bus2_Sel),
      .Rd_Sel1(Rd_Sel1), .Rd_Sel2(Rd_Sel2), .Wr_Sel(Wr_Sel),
      .IR_Load(IR_Load), .MAR_Load(MAR_Load), .PC_Load(PC_Load),
      .PC_Inc(PC_Inc), .Reg_Load(Reg_Load), .CCR_Load(CCR_Load),
      .SP_Inc(SP_Inc), .SP_Dec(SP_Dec), .address(address),
      .to_memory(to_memory), .IR_out(IR_out), .CCR_Result(CCR_Result)
   );

   always #5 Clk = ~Clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: run did not finish");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [7:0] act,
                      input logic [7:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s got %h want %h", name, act, exp);
      end
   endtask

   function automatic vec_t tv(input int fm, alu, b1, b2, rs1, rs2, ws,
                               input int st, tm, ad, ir, cc);
      vec_t v;
      v.fm = 8'(fm);  v.alu = 3'(alu); v.b1 = 2'(b1); v.b2 = 2'(b2);
      v.rs1 = 2'(rs1); v.rs2 = 2'(rs2); v.ws = 2'(ws); v.st = 8'(st);
      v.e_tm = 8'(tm); v.e_addr = 8'(ad); v.e_ir = 8'(ir);
      v.e_ccr = 4'(cc);
      return v;
   endfunction

   function automatic int spv(input int val);
      return SP_EN ? val : 0;
   endfunction

   task automatic drive(input vec_t v);
      from_memory = v.fm;  ALU_Sel = v.alu;
      Bus1_Sel = v.b1;     Bus2_Sel = v.b2;
      Rd_Sel1 = v.rs1;     Rd_Sel2 = v.rs2;  Wr_Sel = v.ws;
      IR_Load = v.st[7];   MAR_Load = v.st[6];
      PC_Load = v.st[5];   PC_Inc = v.st[4];
      Reg_Load = v.st[3];  CCR_Load = v.st[2];
      SP_Inc = v.st[1];    SP_Dec = v.st[0];
   endtask

   task automatic model_reset();
      m_pc = 0; m_mar = 0; m_ir = 0; m_ccr = 0; m_sp = 8'hFF;
      for (int i = 0; i < 4; i++) m_r[i] = 0;
   endtask

   function automatic logic [7:0] m_bus1(input logic [1:0] b1,
                                         input logic [1:0] rs1, rs2);
      case (b1)
         2'd0: return m_pc;
         2'd1: return m_r[rs1];
         2'd2: return m_r[rs2];
         default: return SP_EN ? m_sp : 8'h00;
      endcase
   endfunction

   // Flags from signed/unsigned integer ranges, not bit tricks.
   task automatic m_alu(input logic [2:0] op, input int x, y,
                        output int r, output logic [3:0] f);
      int full, sx, sy, sf;
      logic c, v;
      sx = (x > 127) ? x - 256 : x;
      sy = (y > 127) ? y - 256 : y;
      sf = 0;
      c = 1'b0;
      case (op)
         3'd0: begin full = x + y; sf = sx + sy; c = full > 255; end
         3'd1: begin full = x - y; sf = sx - sy; c = full < 0; end
         3'd2: full = x & y;
         3'd3: full = x | y;
         3'd4: begin full = x + 1; sf = sx + 1; c = full > 255; end
         3'd5: begin full = x - 1; sf = sx - 1; c = full < 0; end
         3'd6: begin
            full = x + y + int'(m_ccr[0]);
            sf = sx + sy + int'(m_ccr[0]);
            c = full > 255;
         end
         default: full = x ^ y;
      endcase
      v = (sf > 127) || (sf < -128);
      r = ((full % 256) + 256) % 256;
      f = {r > 127, r == 0, v, c};
   endtask

   task automatic model_step(input vec_t v);
      int x, y, r;
      logic [3:0] f;
      logic [7:0] b2;
      x = int'(m_bus1(v.b1, v.rs1, v.rs2));
      y = int'(m_r[v.rs2]);
      m_alu(v.alu, x, y, r, f);
      case (v.b2)
         2'd0: b2 = 8'(r);
         2'd1: b2 = 8'(x);
         2'd2: b2 = v.fm;
         default: b2 = 8'h00;
      endcase
      if (v.st[7]) m_ir = b2;
      if (v.st[6]) m_mar = b2;
      if (v.st[5]) m_pc = b2;
      else if (v.st[4]) m_pc = m_pc + 8'd1;
      if (v.st[2]) m_ccr = f;
      if (v.st[3]) m_r[v.ws] = b2;
      if (SP_EN && v.st[1] && !v.st[0]) m_sp = m_sp + 8'd1;
      if (SP_EN && v.st[0] && !v.st[1]) m_sp = m_sp - 8'd1;
   endtask

   // Called just after a falling edge; returns just after the next one.
   task automatic cyc(input vec_t v, input bit use_tab, input int idx);
      string tg;
      tg = use_tab ? $sformatf("row%0d", idx) : $sformatf("rnd%0d", idx);
      drive(v);
      #1;
      if (use_tab) chk({tg, " to_memory"}, to_memory, v.e_tm);
      else chk({tg, " to_memory"}, to_memory, m_bus1(v.b1, v.rs1, v.rs2));
      model_step(v);
      @(posedge Clk);
      #1;
      if (use_tab) begin
         chk({tg, " address"}, address, v.e_addr);
         chk({tg, " IR_out"}, IR_out, v.e_ir);
         chk({tg, " CCR"}, {4'h0, CCR_Result}, {4'h0, v.e_ccr});
      end else begin
         chk({tg, " address"}, address, m_mar);
         chk({tg, " IR_out"}, IR_out, m_ir);
         chk({tg, " CCR"}, {4'h0, CCR_Result}, {4'h0, m_ccr});
      end
      @(negedge Clk);
   endtask

   initial begin
      vec_t v;

      tab[0]  = tv(8'h0A, 0, 0, 2, 0, 0, 0, S_PCL | S_PCI, 8'h01, 0, 0, 0);
      tab[1]  = tv(8'hFF, 0, 0, 2, 0, 0, 0, S_PCL | S_MAR | S_IR,
                   8'h0A, 8'hFF, 8'hFF, 0);
      tab[2]  = tv(0, 0, 0, 0, 0, 0, 0, S_PCI, 8'hFF, 8'hFF, 8'hFF, 0);
      tab[3]  = tv(0, 0, 0, 0, 0, 0, 0, 0, 8'h00, 8'hFF, 8'hFF, 0);
      tab[4]  = tv(8'h7F, 0, 0, 2, 0, 0, 1, S_REG, 8'h00, 8'hFF, 8'hFF, 0);
      tab[5]  = tv(8'h01, 0, 1, 2, 1, 0, 2, S_REG, 8'h7F, 8'hFF, 8'hFF, 0);
      tab[6]  = tv(0, 0, 1, 0, 1, 2, 3, S_REG | S_CCR,
                   8'h7F, 8'hFF, 8'hFF, 4'hA);
      tab[7]  = tv(0, 0, 1, 0, 3, 0, 0, 0, 8'h80, 8'hFF, 8'hFF, 4'hA);
      tab[8]  = tv(8'hFF, 0, 1, 2, 3, 0, 1, S_REG, 8'h80, 8'hFF, 8'hFF, 4'hA);
      tab[9]  = tv(0, 0, 1, 0, 1, 2, 0, S_CCR, 8'hFF, 8'hFF, 8'hFF, 4'h5);
      tab[10] = tv(8'h00, 0, 1, 2, 1, 0, 1, S_REG, 8'hFF, 8'hFF, 8'hFF, 4'h5);
      tab[11] = tv(8'h00, 0, 2, 2, 0, 2, 2, S_REG, 8'h01, 8'hFF, 8'hFF, 4'h5);
      tab[12] = tv(0, 6, 1, 0, 1, 2, 3, S_REG | S_CCR,
                   8'h00, 8'hFF, 8'hFF, 4'h0);
      tab[13] = tv(0, 0, 1, 0, 3, 0, 0, 0, 8'h01, 8'hFF, 8'hFF, 4'h0);
      tab[14] = tv(8'h01, 0, 1, 2, 0, 0, 2, S_REG, 8'h00, 8'hFF, 8'hFF, 4'h0);
      tab[15] = tv(0, 1, 1, 0, 0, 2, 2, S_REG | S_CCR,
                   8'h00, 8'hFF, 8'hFF, 4'h9);
      tab[16] = tv(0, 0, 2, 0, 0, 2, 0, 0, 8'hFF, 8'hFF, 8'hFF, 4'h9);
      tab[17] = tv(0, 0, 3, 0, 0, 0, 0, S_SPD, spv(8'hFF), 8'hFF, 8'hFF, 4'h9);
      tab[18] = tv(0, 0, 3, 0, 0, 0, 0, S_SPD, spv(8'hFE), 8'hFF, 8'hFF, 4'h9);
      tab[19] = tv(0, 0, 3, 0, 0, 0, 0, S_SPD, spv(8'hFD), 8'hFF, 8'hFF, 4'h9);
      tab[20] = tv(0, 0, 3, 0, 0, 0, 0, S_SPI | S_SPD,
                   spv(8'hFC), 8'hFF, 8'hFF, 4'h9);
      tab[21] = tv(0, 0, 3, 0, 0, 0, 0, 0, spv(8'hFC), 8'hFF, 8'hFF, 4'h9);

      drive(tv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      Reset = 1'b0;
      repeat (2) @(negedge Clk);
      chk("por address", address, 8'h00);
      chk("por IR_out", IR_out, 8'h00);
      chk("por CCR", {4'h0, CCR_Result}, 8'h00);
      chk("por to_memory pc", to_memory, 8'h00);
      Bus1_Sel = 2'd3;
      #1 chk("por sp", to_memory, SP_EN ? 8'hFF : 8'h00);
      Bus1_Sel = 2'd0;
      Reset = 1'b1;
      model_reset();
      @(negedge Clk);

      // Make every register nonzero so the mid-cycle reset is visible.
      for (int i = 0; i < 4; i++) begin
         cyc(tv(8'h11 * (i + 1), 1, 1, 2, 0, 1, i,
                S_REG | S_IR | S_MAR | S_PCL | S_CCR | S_SPD,
                0, 0, 0, 0), 1'b0, 100 + i);
      end

      drive(tv(0, 0, 0, 0, 0, 0, 0, S_PCI, 0, 0, 0, 0));
      @(posedge Clk);
      #1 Reset = 1'b0;
      #1;
      chk("rst address", address, 8'h00);
      chk("rst IR_out", IR_out, 8'h00);
      chk("rst CCR", {4'h0, CCR_Result}, 8'h00);
      chk("rst pc", to_memory, 8'h00);
      Bus1_Sel = 2'd1;
      for (int i = 0; i < 4; i++) begin
         Rd_Sel1 = 2'(i);
         #1 chk($sformatf("rst r%0d", i), to_memory, 8'h00);
      end
      Bus1_Sel = 2'd3;
      #1 chk("rst sp", to_memory, SP_EN ? 8'hFF : 8'h00);
      Bus1_Sel = 2'd0;
      @(posedge Clk);
      #1 chk("rst pc_inc ignored", to_memory, 8'h00);
      @(negedge Clk);
      Reset = 1'b1;
      model_reset();
      cyc(tv(0, 0, 0, 0, 0, 0, 0, S_PCI, 0, 0, 0, 0), 1'b0, 200);
      drive(tv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      #1 chk("pc after reset", to_memory, 8'h01);

      for (int i = 0; i < 22; i++) cyc(tab[i], 1'b1, i);

      for (int i = 0; i < 300; i++) begin
         v.fm  = 8'($urandom);
         v.alu = 3'($urandom);
         v.b1  = 2'($urandom);
         v.b2  = 2'($urandom);
         v.rs1 = 2'($urandom);
         v.rs2 = 2'($urandom);
         v.ws  = 2'($urandom);
         v.st  = 8'($urandom);
         v.e_tm = 0; v.e_addr = 0; v.e_ir = 0; v.e_ccr = 0;
         cyc(v, 1'b0, i);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
